// File: rtl/memory_stage_if.sv
// EX/MEM pipeline bundle: the registered execute-stage outputs consumed by
// memory_stage.
//   master : execute side (drives every field)
//   slave  : memory stage (samples every field)
// Fields: alu_result/read_data1/read_data2 data, memory command strobes,
// address and write-source selects, PC/flags for CALL/RET, immediate and
// input-port values, and the write-back control that rides along.
interface memory_stage_if;
    logic [15:0] alu_result;
    logic [15:0] read_data1;
    logic [15:0] read_data2;
    logic        mem_read;
    logic        mem_write;
    logic        mem_push;
    logic        mem_pop;
    logic        flag_pop;
    logic        pc_choose_memory;
    logic [1:0]  memory_address_select;
    logic [1:0]  memory_write_src_select;
    logic [31:0] pc_plus_one;
    logic [2:0]  flags;
    logic [15:0] LDM_value;
    logic [15:0] inport_value;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic [2:0]  reg_write_address;
    logic        outport_enable;

    modport master (
        output alu_result, read_data1, read_data2,
        output mem_read, mem_write, mem_push, mem_pop, flag_pop, pc_choose_memory,
        output memory_address_select, memory_write_src_select,
        output pc_plus_one, flags, LDM_value, inport_value,
        output reg_write, wb_sel, reg_write_address, outport_enable
    );

    modport slave (
        input alu_result, read_data1, read_data2,
        input mem_read, mem_write, mem_push, mem_pop, flag_pop, pc_choose_memory,
        input memory_address_select, memory_write_src_select,
        input pc_plus_one, flags, LDM_value, inport_value,
        input reg_write, wb_sel, reg_write_address, outport_enable
    );
endinterface

// File: rtl/memory_stage.sv
// memory_stage: consumer end of the EX/MEM pipeline interface.
// Performs data-memory load/store, 16-bit stack push/pop, two-word PC
// push (CALL) / pop (RET) and flag-word pop, and drives the MEM/WB register.
//
// Ports
//   clk, reset (async, active low)
//   ex_mem                      EX/MEM bundle (slave modport)
//   wb_data, reg_write_out, reg_write_address_out, outport_enable_out,
//   alu_result_from_mem         MEM/WB register
//   new_pc, new_pc_valid        popped return address + one-cycle strobe
//   conditions_from_memory_pop,
//   flags_restore               popped flags + one-cycle strobe
//   stall                       freezes IF/ID/EX and EX/MEM for two-cycle ops
//   sp_out                      current stack pointer
//   stack_fault                 sticky stack over/underflow (STACK_GUARD_EN)
//
// Build option: define STACK_GUARD_EN to enable stack overflow/underflow
// detection; otherwise SP wraps silently and stack_fault is tied low.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | accepts commands; single-word ops complete here
// PUSH2 | second word of CALL: writes latched low PC half at SP
// POP2  | second word of RET: reads high PC half at SP+1, issues new_pc
module memory_stage #(
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] SP_RESET = '1
) (
    input  logic                 clk,
    input  logic                 reset,
    memory_stage_if.slave        ex_mem,
    output logic [15:0]          wb_data,
    output logic                 reg_write_out,
    output logic [2:0]           reg_write_address_out,
    output logic                 outport_enable_out,
    output logic [15:0]          alu_result_from_mem,
    output logic [31:0]          new_pc,
    output logic                 new_pc_valid,
    output logic [2:0]           conditions_from_memory_pop,
    output logic                 flags_restore,
    output logic                 stall,
    output logic [ADDR_W-1:0]    sp_out,
    output logic                 stack_fault
);
    localparam int                DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] SP_ONE = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PUSH2 = 2'b01,
        POP2  = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic [ADDR_W-1:0] sp_plus_one, sp_minus_one;
    logic [15:0]       pc_word_q, pc_word_d;

    logic [15:0]       mem [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [15:0]       mem_wdata;

    logic [ADDR_W-1:0] data_addr;
    logic              data_addr_valid;
    logic [15:0]       data_rdata;
    logic [15:0]       pop_rdata;
    logic [15:0]       load_rdata;
    logic [15:0]       write_src;
    logic [15:0]       wb_mux;

    logic              push_cmd, pop_cmd;
    logic              overflow, underflow_idle, underflow_pop2;
    logic              fault_set;
    logic              pc_pop_done;
    logic              flag_pop_done;

    assign sp_plus_one  = sp_q + SP_ONE;
    assign sp_minus_one = sp_q - SP_ONE;
    assign sp_out       = sp_q;

    // Simultaneous push and pop is treated as no stack command at all.
    assign push_cmd = ex_mem.mem_push & ~ex_mem.mem_pop;
    assign pop_cmd  = ex_mem.mem_pop & ~ex_mem.mem_push;

`ifdef STACK_GUARD_EN
    assign overflow       = push_cmd && (sp_q == '0);
    assign underflow_idle = pop_cmd && (sp_q == SP_RESET);
    assign underflow_pop2 = (sp_plus_one == '0);
`else
    assign overflow       = 1'b0;
    assign underflow_idle = 1'b0;
    assign underflow_pop2 = 1'b0;
`endif

    // Load/store address. Stack operations always address through SP.
    always_comb begin
        data_addr       = ex_mem.alu_result[ADDR_W-1:0];
        data_addr_valid = 1'b1;
        case (ex_mem.memory_address_select)
            2'b00:   data_addr = ex_mem.alu_result[ADDR_W-1:0];
            2'b01:   data_addr = sp_q;
            2'b10:   data_addr = sp_plus_one;
            default: data_addr_valid = 1'b0;
        endcase
    end

    always_comb begin
        write_src = ex_mem.read_data2;
        case (ex_mem.memory_write_src_select)
            2'b00:   write_src = ex_mem.read_data2;
            2'b01:   write_src = ex_mem.read_data1;
            2'b10:   write_src = ex_mem.pc_plus_one[15:0];
            default: write_src = {13'b0, ex_mem.flags};
        endcase
    end

    // Two combinational read ports: one for load/store, one for pops.
    assign data_rdata = data_addr_valid ? mem[data_addr] : 16'h0000;
    assign pop_rdata  = mem[sp_plus_one];
    assign load_rdata = ((state_q == POP2) || ((state_q == IDLE) && pop_cmd))
                        ? pop_rdata : data_rdata;

    always_comb begin
        wb_mux = ex_mem.alu_result;
        case (ex_mem.wb_sel)
            2'b00:   wb_mux = ex_mem.alu_result;
            2'b01:   wb_mux = load_rdata;
            2'b10:   wb_mux = ex_mem.LDM_value;
            default: wb_mux = ex_mem.inport_value;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        sp_d          = sp_q;
        pc_word_d     = pc_word_q;
        mem_we        = 1'b0;
        mem_waddr     = sp_q;
        mem_wdata     = write_src;
        stall         = 1'b0;
        fault_set     = 1'b0;
        pc_pop_done   = 1'b0;
        flag_pop_done = 1'b0;

        case (state_q)
            IDLE: begin
                if (push_cmd) begin
                    if (overflow) begin
                        fault_set = 1'b1;
                    end else if (ex_mem.pc_choose_memory) begin
                        mem_we    = 1'b1;
                        mem_wdata = ex_mem.pc_plus_one[31:16];
                        pc_word_d = ex_mem.pc_plus_one[15:0];
                        sp_d      = sp_minus_one;
                        stall     = 1'b1;
                        state_d   = PUSH2;
                    end else begin
                        mem_we = 1'b1;
                        sp_d   = sp_minus_one;
                    end
                end else if (pop_cmd) begin
                    if (underflow_idle) begin
                        fault_set = 1'b1;
                    end else if (ex_mem.pc_choose_memory) begin
                        pc_word_d = pop_rdata;
                        sp_d      = sp_plus_one;
                        stall     = 1'b1;
                        state_d   = POP2;
                    end else begin
                        sp_d          = sp_plus_one;
                        flag_pop_done = ex_mem.flag_pop;
                    end
                end else if (ex_mem.mem_write && !ex_mem.mem_push && data_addr_valid) begin
                    mem_we    = 1'b1;
                    mem_waddr = data_addr;
                end
            end
            PUSH2: begin
                mem_we    = 1'b1;
                mem_wdata = pc_word_q;
                sp_d      = sp_minus_one;
                state_d   = IDLE;
            end
            POP2: begin
                state_d = IDLE;
                if (underflow_pop2) begin
                    fault_set = 1'b1;
                end else begin
                    sp_d        = sp_plus_one;
                    pc_pop_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q                    <= IDLE;
            sp_q                       <= SP_RESET;
            pc_word_q                  <= 16'h0000;
            wb_data                    <= 16'h0000;
            reg_write_out              <= 1'b0;
            reg_write_address_out      <= 3'b000;
            outport_enable_out         <= 1'b0;
            alu_result_from_mem        <= 16'h0000;
            new_pc                     <= 32'h0000_0000;
            new_pc_valid               <= 1'b0;
            conditions_from_memory_pop <= 3'b000;
            flags_restore              <= 1'b0;
        end else begin
            state_q       <= state_d;
            sp_q          <= sp_d;
            pc_word_q     <= pc_word_d;
            new_pc_valid  <= 1'b0;
            flags_restore <= 1'b0;

            if (pc_pop_done) begin
                new_pc       <= {pop_rdata, pc_word_q};
                new_pc_valid <= 1'b1;
            end
            if (flag_pop_done) begin
                conditions_from_memory_pop <= pop_rdata[2:0];
                flags_restore              <= 1'b1;
            end
            // MEM/WB freezes only on the first cycle of a two-cycle op.
            if (!stall) begin
                wb_data               <= wb_mux;
                reg_write_out         <= ex_mem.reg_write;
                reg_write_address_out <= ex_mem.reg_write_address;
                outport_enable_out    <= ex_mem.outport_enable;
                alu_result_from_mem   <= ex_mem.alu_result;
            end
        end
    end

`ifdef STACK_GUARD_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stack_fault <= 1'b0;
        end else if (fault_set) begin
            stack_fault <= 1'b1;
        end
    end
`else
    logic fault_set_unused;
    assign fault_set_unused = fault_set;
    assign stack_fault      = 1'b0;
`endif

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;
    logic        clk;
    logic        reset;
    logic [15:0] wb_data;
    logic        reg_write_out;
    logic [2:0]  reg_write_address_out;
    logic        outport_enable_out;
    logic [15:0] alu_result_from_mem;
    logic [31:0] new_pc;
    logic        new_pc_valid;
    logic [2:0]  conditions_from_memory_pop;
    logic        flags_restore;
    logic        stall;
    logic [11:0] sp_out;
    logic        stack_fault;

    int checks;
    int errors;

    memory_stage_if ex_mem ();

    memory_stage dut (
        .clk                        (clk),
        .reset                      (reset),
        .ex_mem                     (ex_mem.slave),
        .wb_data                    (wb_data),
        .reg_write_out              (reg_write_out),
        .reg_write_address_out      (reg_write_address_out),
        .outport_enable_out         (outport_enable_out),
        .alu_result_from_mem        (alu_result_from_mem),
        .new_pc                     (new_pc),
        .new_pc_valid               (new_pc_valid),
        .conditions_from_memory_pop (conditions_from_memory_pop),
        .flags_restore              (flags_restore),
        .stall                      (stall),
        .sp_out                     (sp_out),
        .stack_fault                (stack_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cmd();
        ex_mem.alu_result              = 16'h0000;
        ex_mem.read_data1              = 16'h0000;
        ex_mem.read_data2              = 16'h0000;
        ex_mem.mem_read                = 1'b0;
        ex_mem.mem_write               = 1'b0;
        ex_mem.mem_push                = 1'b0;
        ex_mem.mem_pop                 = 1'b0;
        ex_mem.flag_pop                = 1'b0;
        ex_mem.pc_choose_memory        = 1'b0;
        ex_mem.memory_address_select   = 2'b00;
        ex_mem.memory_write_src_select = 2'b00;
        ex_mem.pc_plus_one             = 32'h0000_0000;
        ex_mem.flags                   = 3'b000;
        ex_mem.LDM_value               = 16'h0000;
        ex_mem.inport_value            = 16'h0000;
        ex_mem.reg_write               = 1'b0;
        ex_mem.wb_sel                  = 2'b00;
        ex_mem.reg_write_address       = 3'b000;
        ex_mem.outport_enable          = 1'b0;
    endtask

    task automatic load_word(input logic [15:0] addr);
        clear_cmd();
        ex_mem.mem_read   = 1'b1;
        ex_mem.alu_result = addr;
        ex_mem.wb_sel     = 2'b01;
        ex_mem.reg_write  = 1'b1;
        step();
    endtask

    initial begin
        logic saw_valid;
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        clear_cmd();

        // Reset state
        #22;
        check("reset_sp", 32'(sp_out), 32'd4095);
        check("reset_wb_data", 32'(wb_data), 32'h0);
        check("reset_stall", 32'(stall), 32'h0);
        check("reset_new_pc_valid", 32'(new_pc_valid), 32'h0);
        check("reset_stack_fault", 32'(stack_fault), 32'h0);
        reset = 1'b1;

        // Store BEEF at 0x0010
        ex_mem.mem_write  = 1'b1;
        ex_mem.alu_result = 16'h0010;
        ex_mem.read_data2 = 16'hBEEF;
        step();
        check("store_wb_alu", 32'(wb_data), 32'h0010);

        // Load it back, with write-back controls
        clear_cmd();
        ex_mem.mem_read          = 1'b1;
        ex_mem.alu_result        = 16'h0010;
        ex_mem.wb_sel            = 2'b01;
        ex_mem.reg_write         = 1'b1;
        ex_mem.reg_write_address = 3'd5;
        ex_mem.outport_enable    = 1'b1;
        step();
        check("load_wb_data", 32'(wb_data), 32'hBEEF);
        check("load_reg_write", 32'(reg_write_out), 32'h1);
        check("load_reg_addr", 32'(reg_write_address_out), 32'h5);
        check("load_outport", 32'(outport_enable_out), 32'h1);
        check("load_alu_fwd", 32'(alu_result_from_mem), 32'h0010);

        // Write and read together: read returns pre-write contents
        clear_cmd();
        ex_mem.mem_write  = 1'b1;
        ex_mem.mem_read   = 1'b1;
        ex_mem.alu_result = 16'h0010;
        ex_mem.read_data2 = 16'h1234;
        ex_mem.wb_sel     = 2'b01;
        step();
        check("rw_prewrite", 32'(wb_data), 32'hBEEF);
        load_word(16'h0010);
        check("rw_written", 32'(wb_data), 32'h1234);

        // Reserved address select: no write
        clear_cmd();
        ex_mem.mem_write             = 1'b1;
        ex_mem.memory_address_select = 2'b11;
        ex_mem.alu_result            = 16'h0010;
        ex_mem.read_data2            = 16'hDEAD;
        step();
        load_word(16'h0010);
        check("sel11_no_write", 32'(wb_data), 32'h1234);

        // Store from read_data1 and LDM / inport write-back paths
        clear_cmd();
        ex_mem.mem_write               = 1'b1;
        ex_mem.memory_write_src_select = 2'b01;
        ex_mem.alu_result              = 16'h0020;
        ex_mem.read_data1              = 16'hC0DE;
        ex_mem.LDM_value               = 16'h5A5A;
        ex_mem.wb_sel                  = 2'b10;
        step();
        check("ldm_wb", 32'(wb_data), 32'h5A5A);
        load_word(16'h0020);
        check("store_rd1", 32'(wb_data), 32'hC0DE);
        clear_cmd();
        ex_mem.inport_value = 16'h7777;
        ex_mem.wb_sel       = 2'b11;
        step();
        check("inport_wb", 32'(wb_data), 32'h7777);

        // CALL: PC push
        clear_cmd();
        ex_mem.mem_push                = 1'b1;
        ex_mem.pc_choose_memory        = 1'b1;
        ex_mem.memory_write_src_select = 2'b10;
        ex_mem.pc_plus_one             = 32'h0001_2345;
        #1;
        check("call_stall_first", 32'(stall), 32'h1);
        step();
        check("call_stall_second", 32'(stall), 32'h0);
        check("call_sp_mid", 32'(sp_out), 32'd4094);
        step();
        clear_cmd();
        #1;
        check("call_sp_end", 32'(sp_out), 32'd4093);
        check("call_stall_after", 32'(stall), 32'h0);

        // RET: PC pop
        ex_mem.mem_pop          = 1'b1;
        ex_mem.pc_choose_memory = 1'b1;
        #1;
        check("ret_stall_first", 32'(stall), 32'h1);
        step();
        check("ret_stall_second", 32'(stall), 32'h0);
        check("ret_valid_early", 32'(new_pc_valid), 32'h0);
        step();
        clear_cmd();
        check("ret_new_pc", new_pc, 32'h0001_2345);
        check("ret_valid", 32'(new_pc_valid), 32'h1);
        check("ret_sp", 32'(sp_out), 32'd4095);
        step();
        check("ret_valid_once", 32'(new_pc_valid), 32'h0);

        // Pushed words remain in memory
        load_word(16'h0FFF);
        check("mem_4095", 32'(wb_data), 32'h0001);
        load_word(16'h0FFE);
        check("mem_4094", 32'(wb_data), 32'h2345);

        // Flag push then flag pop
        clear_cmd();
        ex_mem.mem_push                = 1'b1;
        ex_mem.memory_write_src_select = 2'b11;
        ex_mem.flags                   = 3'b101;
        step();
        check("flagpush_sp", 32'(sp_out), 32'd4094);
        clear_cmd();
        ex_mem.mem_pop   = 1'b1;
        ex_mem.flag_pop  = 1'b1;
        ex_mem.wb_sel    = 2'b01;
        ex_mem.reg_write = 1'b1;
        step();
        clear_cmd();
        check("flagpop_cond", 32'(conditions_from_memory_pop), 32'h5);
        check("flagpop_restore", 32'(flags_restore), 32'h1);
        check("flagpop_wb", 32'(wb_data), 32'h0005);
        check("flagpop_sp", 32'(sp_out), 32'd4095);
        step();
        check("flagpop_once", 32'(flags_restore), 32'h0);

        // Push and pop together: SP unchanged
        ex_mem.mem_push = 1'b1;
        ex_mem.mem_pop  = 1'b1;
        step();
        clear_cmd();
        check("pushpop_sp", 32'(sp_out), 32'd4095);

        // Reset during POP2
        ex_mem.mem_push         = 1'b1;
        ex_mem.pc_choose_memory = 1'b1;
        ex_mem.pc_plus_one      = 32'hABCD_0001;
        step();
        step();
        clear_cmd();
        ex_mem.mem_pop          = 1'b1;
        ex_mem.pc_choose_memory = 1'b1;
        step();
        check("pop2_sp_before_reset", 32'(sp_out), 32'd4094);
        #2;
        reset = 1'b0;
        clear_cmd();
        #1;
        check("rst_pop2_sp", 32'(sp_out), 32'd4095);
        check("rst_pop2_stall", 32'(stall), 32'h0);
        check("rst_pop2_new_pc", new_pc, 32'h0);
        #2;
        reset = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (new_pc_valid) saw_valid = 1'b1;
        end
        check("rst_pop2_no_valid", 32'(saw_valid), 32'h0);
        check("rst_pop2_sp_after", 32'(sp_out), 32'd4095);

        // Pop at SP_RESET
        ex_mem.mem_pop = 1'b1;
        step();
        clear_cmd();
`ifdef STACK_GUARD_EN
        check("underflow_fault", 32'(stack_fault), 32'h1);
        check("underflow_sp", 32'(sp_out), 32'd4095);
`else
        check("wrap_fault", 32'(stack_fault), 32'h0);
        check("wrap_sp", 32'(sp_out), 32'd0);
`endif
        ex_mem.mem_push = 1'b1;
        step();
        clear_cmd();
`ifdef STACK_GUARD_EN
        check("fault_sticky", 32'(stack_fault), 32'h1);
        check("guard_push_sp", 32'(sp_out), 32'd4094);
`else
        check("wrap_fault_push", 32'(stack_fault), 32'h0);
        check("wrap_push_sp", 32'(sp_out), 32'd4095);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Consumer end of the EX/MEM pipeline interface.
- Takes the registered execute-stage outputs and performs data-memory load/store and 16-bit stack push/pop.
- Performs two-word 32-bit PC push (CALL) and pop (RET), and a flag-word pop.
- Drives the MEM/WB pipeline register, the forwarding value back to execute, the popped PC/flags, and a stall to freeze upstream stages during two-cycle stack operations.

Parameters:
- ADDR_W, 12: data-memory address width; memory is 2^ADDR_W words of 16 bits.
- SP_RESET, 2^ADDR_W-1: stack-pointer reset value (stack grows downward).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- alu_result  in  16  EX/MEM ALU result; effective address for LDD/STD
- read_data1  in  16  forwarded Rdest
- read_data2  in  16  forwarded Rsrc
- mem_read  in  1  load
- mem_write  in  1  store
- mem_push  in  1  push
- mem_pop  in  1  pop
- flag_pop  in  1  with mem_pop: popped word restores flags
- pc_choose_memory  in  1  with push/pop: 32-bit PC operation
- memory_address_select  in  2  00 alu_result, 01 SP, 10 SP+1, 11 reserved (no access)
- memory_write_src_select  in  2  00 read_data2, 01 read_data1, 10 pc_plus_one, 11 {13'b0,flags}
- pc_plus_one  in  32  return address
- flags  in  3  {C,N,Z} from execute
- LDM_value  in  16  immediate
- inport_value  in  16  input-port value
- reg_write  in  1  write-back enable
- wb_sel  in  2  00 ALU, 01 memory, 10 LDM, 11 input port
- reg_write_address  in  3  destination register
- outport_enable  in  1  OUT instruction
- wb_data  out  16  MEM/WB write-back data
- reg_write_out  out  1  MEM/WB
- reg_write_address_out  out  3  MEM/WB
- outport_enable_out  out  1  MEM/WB
- alu_result_from_mem  out  16  MEM/WB copy of alu_result, fed to execute forwarding
- new_pc  out  32  popped PC
- new_pc_valid  out  1  one-cycle strobe
- conditions_from_memory_pop  out  3  popped flags
- flags_restore  out  1  one-cycle strobe
- stall  out  1  holds IF/ID/EX and the EX/MEM register
- sp_out  out  ADDR_W  current stack pointer
- stack_fault  out  1  see Optional Feature

Behaviour:
- Reset (reset=0, asynchronous): SP=SP_RESET, FSM=IDLE, all registered outputs 0. Memory contents are not cleared.
- Memory reads are combinational; writes occur on the clock edge.
- MEM/WB outputs update one clock after inputs are presented.
- MEM/WB register holds its value while stall=1. It loads normally on the final cycle of a two-cycle operation.
- Address is the low ADDR_W bits of the selected source. SP arithmetic wraps modulo 2^ADDR_W.

Single-word operations (FSM=IDLE):
- Store: M[addr] <= selected source.
- Load: memory word is routed to wb_data when wb_sel=01.
- Push (not PC): M[SP] <= source; SP <= SP-1.
- Pop (not PC): data = M[SP+1]; SP <= SP+1.
- If flag_pop=1 on a pop: conditions_from_memory_pop <= data[2:0] and flags_restore=1 for one cycle.

PC push, pc_choose_memory=1:
- IDLE: M[SP] <= pc_plus_one[31:16]; latch pc_plus_one[15:0]; SP <= SP-1; stall=1; go to PUSH2.
- PUSH2: M[SP] <= latched low word; SP <= SP-1; stall=0; return to IDLE.

PC pop, pc_choose_memory=1:
- IDLE: latch low word = M[SP+1]; SP <= SP+1; stall=1; go to POP2.
- POP2: high word = M[SP+1]; SP <= SP+1; new_pc <= {high, low}; new_pc_valid=1 on the next cycle; stall=0; return to IDLE.

Command priority and exceptions:
- While in PUSH2 or POP2, command inputs are ignored; only latched state is used.
- mem_push and mem_pop both asserted: no access, SP unchanged.
- mem_write together with mem_read: the write occurs; read data is the pre-write contents.
- memory_address_select=11: no memory access.

Reset mid-operation:
- Returns to IDLE with the SP value forced to SP_RESET.
- A partially pushed PC is left in memory; no new_pc_valid is issued.

Optional Feature:
- Macro: STACK_GUARD_EN.
- Enabled:
  - A push (or the first word of a PC push) with SP==0 is an overflow.
  - A pop with SP==SP_RESET, or a POP2 where SP+1 would wrap, is an underflow.
  - On either fault: the access is suppressed, SP holds, FSM returns to IDLE, no valid strobes are issued.
  - stack_fault is set and stays set until reset.
- Disabled: SP wraps silently; stack_fault is tied to 0.

Test Plan:
- Store then load: STD read_data2=16'hBEEF at alu_result=16'h0010, then LDD same address with wb_sel=01 -> wb_data=16'hBEEF one cycle later.
- PC push: SP=4095, CALL with pc_plus_one=32'h0001_2345 -> M[4095]=16'h0001, M[4094]=16'h2345, stall high exactly one cycle, SP=4093.
- PC pop: RET immediately after the PC push -> new_pc=32'h0001_2345, new_pc_valid pulses once, SP=4095, stall high exactly one cycle.
- Flag pop: push {13'b0,3'b101}, then pop with flag_pop=1 -> conditions_from_memory_pop=3'b101, flags_restore pulses once.
- Reset in POP2: reset asserted low -> SP=4095, stall=0, new_pc_valid never asserts.
- Underflow with STACK_GUARD_EN: pop at SP=4095 -> stack_fault=1, SP stays 4095. Without the macro: SP wraps to 0.
